fp_add_arbiter: RTL and testbench

- Shares one external registered fp32 add/select unit between N requesters.
- The unit takes operands a and b and a 3-bit one-hot select: bit2 passes a, bit1 passes b, bit0 returns a+b; select 000 yields 0.
- Round-robin arbitration, with one operation issued per cycle through a registered issue stage.
- Tracks in-flight operations and returns each result tagged with its requester id.

---
 rtl/fp_add_arbiter.sv | 166 ++++++++++++++++
 tb/tb_fp_add_arbiter.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_add_arbiter.sv
// fp_add_arbiter
//   Shares one external registered fp32 add/select unit between N requesters.
//   A round-robin arbiter grants at most one requester per cycle. The granted
//   operands and one-hot select are registered into the issue stage. A small
//   {valid,id} shift register follows each issue through the unit so that the
//   result can be returned tagged with the id of the requester that issued it.
//
// Parameters
//   N    number of requesters (2..8)
//   IDW  requester id width, 2**IDW >= N
//   LAT  register stages inside the external unit (1..4)
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   req_valid/ready   per-requester handshake (ready is one-hot or zero)
//   req_a, req_b      32-bit operands, slice i belongs to requester i
//   req_op            2-bit op per requester: 0 add, 1 pass a, 2 pass b, 3 zero
//   add_a, add_b      registered operands to the unit
//   add_ctrl          registered one-hot select: bit2 a, bit1 b, bit0 a+b
//   add_out           unit result, valid LAT cycles after its inputs change
//   rsp_valid/id/data registered result with requester id (no backpressure)
//   busy              any operation in flight
//
// Optional feature (macro ARB_STATS_EN)
//   stats_clr         synchronous clear of all grant counters
//   grant_cnt         16-bit saturating handshake counter per requester

module fp_add_arbiter #(
  parameter int N   = 4,
  parameter int IDW = 2,
  parameter int LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N-1:0]      req_valid,
  output logic [N-1:0]      req_ready,
  input  logic [32*N-1:0]   req_a,
  input  logic [32*N-1:0]   req_b,
  input  logic [2*N-1:0]    req_op,
  output logic [31:0]       add_a,
  output logic [31:0]       add_b,
  output logic [2:0]        add_ctrl,
  input  logic [31:0]       add_out,
  output logic              rsp_valid,
  output logic [IDW-1:0]    rsp_id,
  output logic [31:0]       rsp_data,
  output logic              busy
`ifdef ARB_STATS_EN
  ,
  input  logic              stats_clr,
  output logic [16*N-1:0]   grant_cnt
`endif
);

  logic [IDW-1:0] ptr;
  logic           grant_any;
  logic [IDW-1:0] grant_id;
  logic [IDW-1:0] next_ptr;
  logic [31:0]    sel_a;
  logic [31:0]    sel_b;
  logic [1:0]     sel_op;

  logic [LAT:0]   pipe_v;
  logic [IDW-1:0] pipe_id [0:LAT];

  // Round-robin search: distance k from the pointer is the outer loop so the
  // first valid requester found is the nearest one at or after the pointer.
  // Holding req_ready low during reset keeps the handshake quiet until release.
  always_comb begin
    grant_any = 1'b0;
    grant_id  = '0;
    next_ptr  = ptr;
    sel_a     = '0;
    sel_b     = '0;
    sel_op    = '0;
    req_ready = '0;
    for (int k = 0; k < N; k++) begin
      for (int i = 0; i < N; i++) begin
        if (!grant_any && rst_n && req_valid[i] && (((int'(ptr) + k) % N) == i)) begin
          grant_any    = 1'b1;
          grant_id     = IDW'(i);
          next_ptr     = IDW'((i + 1) % N);
          sel_a        = req_a[32*i +: 32];
          sel_b        = req_b[32*i +: 32];
          sel_op       = req_op[2*i +: 2];
          req_ready[i] = 1'b1;
        end
      end
    end
  end

  // Issue stage: operands hold when idle, only the select drops to zero so the
  // unit produces 0 for idle slots.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr      <= '0;
      add_a    <= '0;
      add_b    <= '0;
      add_ctrl <= 3'b000;
    end else if (grant_any) begin
      ptr   <= next_ptr;
      add_a <= sel_a;
      add_b <= sel_b;
      case (sel_op)
        2'd0:    add_ctrl <= 3'b001;
        2'd1:    add_ctrl <= 3'b100;
        2'd2:    add_ctrl <= 3'b010;
        default: add_ctrl <= 3'b000;
      endcase
    end else begin
      add_ctrl <= 3'b000;
    end
  end

  // Tracking pipe: stage LAT holds the tag whose result is on add_out now.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_v <= '0;
      for (int s = 0; s <= LAT; s++) pipe_id[s] <= '0;
    end else begin
      pipe_v     <= {pipe_v[LAT-1:0], grant_any};
      pipe_id[0] <= grant_any ? grant_id : '0;
      for (int s = 1; s <= LAT; s++) pipe_id[s] <= pipe_id[s-1];
    end
  end

  // Response stage: data and id only update for a valid tail.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_data  <= '0;
    end else begin
      rsp_valid <= pipe_v[LAT];
      if (pipe_v[LAT]) begin
        rsp_id   <= pipe_id[LAT];
        rsp_data <= add_out;
      end
    end
  end

  assign busy = (|pipe_v) | rsp_valid;

`ifdef ARB_STATS_EN
  logic [15:0] cnt [0:N-1];

  // Clear has priority over a same-cycle handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) cnt[i] <= '0;
    end else if (stats_clr) begin
      for (int i = 0; i < N; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (req_valid[i] && req_ready[i] && (cnt[i] != 16'hFFFF)) cnt[i] <= cnt[i] + 16'd1;
      end
    end
  end

  always_comb begin
    grant_cnt = '0;
    for (int i = 0; i < N; i++) grant_cnt[16*i +: 16] = cnt[i];
  end
`endif

endmodule

// File: tb/tb_fp_add_arbiter.sv
// tb_fp_add_arbiter
//   Directed bench for fp_add_arbiter with N=4, IDW=2, LAT=1. It models the
//   external unit as one register stage; expected values are hand constants.

module tb_fp_add_arbiter;

  localparam int N   = 4;
  localparam int IDW = 2;
  localparam int LAT = 1;

  logic              clk;
  logic              rst_n;
  logic [N-1:0]      req_valid;
  logic [N-1:0]      req_ready;
  logic [32*N-1:0]   req_a;
  logic [32*N-1:0]   req_b;
  logic [2*N-1:0]    req_op;
  logic [31:0]       add_a;
  logic [31:0]       add_b;
  logic [2:0]        add_ctrl;
  logic [31:0]       add_out;
  logic              rsp_valid;
  logic [IDW-1:0]    rsp_id;
  logic [31:0]       rsp_data;
  logic              busy;
`ifdef ARB_STATS_EN
  logic              stats_clr;
  logic [16*N-1:0]   grant_cnt;
`endif

  int errors = 0;
  int checks = 0;

  fp_add_arbiter #(.N(N), .IDW(IDW), .LAT(LAT)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_op    (req_op),
    .add_a     (add_a),
    .add_b     (add_b),
    .add_ctrl  (add_ctrl),
    .add_out   (add_out),
    .rsp_valid (rsp_valid),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data),
    .busy      (busy)
`ifdef ARB_STATS_EN
    ,
    .stats_clr (stats_clr),
    .grant_cnt (grant_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // fp32 <-> real for normal numbers and zero, enough for the directed values.
  function automatic real f2r(input logic [31:0] f);
    logic [63:0] d;
    if (f[30:0] == 31'd0) return 0.0;
    d = {f[31], 11'(f[30:23]) + 11'd896, f[22:0], 29'd0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] r2f(input real r);
    logic [63:0] d;
    logic [10:0] e;
    d = $realtobits(r);
    if (d[62:0] == 63'd0) return 32'd0;
    e = d[62:52] - 11'd896;
    return {d[63], e[7:0], d[51:29]};
  endfunction

  function automatic logic [31:0] unit_model(input logic [31:0] a, input logic [31:0] b,
                                              input logic [2:0] ctrl);
    case (ctrl)
      3'b100:  return a;
      3'b010:  return b;
      3'b001:  return r2f(f2r(a) + f2r(b));
      default: return 32'd0;
    endcase
  endfunction

  // External unit with a single register stage.
  always_ff @(posedge clk) add_out <= unit_model(add_a, add_b, add_ctrl);

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    req_valid = '0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    req_valid = 4'b1010;
    #2;
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("[TB] FAIL reset_ready got %b expected 0000", req_ready); end
    checks++; if (add_a !== 32'd0) begin errors++; $display("[TB] FAIL reset_add_a got %h expected 0", add_a); end
    checks++; if (add_b !== 32'd0) begin errors++; $display("[TB] FAIL reset_add_b got %h expected 0", add_b); end
    checks++; if (add_ctrl !== 3'b000) begin errors++; $display("[TB] FAIL reset_ctrl got %b expected 000", add_ctrl); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_rsp_valid got %b expected 0", rsp_valid); end
    checks++; if (rsp_id !== 2'd0) begin errors++; $display("[TB] FAIL reset_rsp_id got %0d expected 0", rsp_id); end
    checks++; if (rsp_data !== 32'd0) begin errors++; $display("[TB] FAIL reset_rsp_data got %h expected 0", rsp_data); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got %b expected 0", busy); end
    step();
    step();
    rst_n = 1'b1;
    #1;
    checks++; if (req_ready !== 4'b0010) begin errors++; $display("[TB] FAIL first_grant_lowest got %b expected 0010", req_ready); end
    req_valid = '0;
    step();
  endtask

  task automatic test_single_add();
    do_reset();
    req_valid          = 4'b0010;
    req_a[32*1 +: 32]  = 32'h3F800000;
    req_b[32*1 +: 32]  = 32'h40000000;
    req_op[2*1 +: 2]   = 2'd0;
    #1;
    checks++; if (req_ready !== 4'b0010) begin errors++; $display("[TB] FAIL add_ready got %b expected 0010", req_ready); end
    step();
    req_valid = '0;
    checks++; if (add_ctrl !== 3'b001) begin errors++; $display("[TB] FAIL add_ctrl got %b expected 001", add_ctrl); end
    checks++; if (add_a !== 32'h3F800000) begin errors++; $display("[TB] FAIL add_a got %h expected 3f800000", add_a); end
    checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL add_busy got %b expected 1", busy); end
    step();
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("[TB] FAIL add_early_rsp got %b expected 0", rsp_valid); end
    step();
    checks++; if (rsp_valid !== 1'b1) begin errors++; $display("[TB] FAIL add_rsp_valid got %b expected 1", rsp_valid); end
    checks++; if (rsp_id !== 2'd1) begin errors++; $display("[TB] FAIL add_rsp_id got %0d expected 1", rsp_id); end
    checks++; if (rsp_data !== 32'h40400000) begin errors++; $display("[TB] FAIL add_rsp_data got %h expected 40400000", rsp_data); end
    step();
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("[TB] FAIL add_rsp_drop got %b expected 0", rsp_valid); end
    checks++; if (rsp_data !== 32'h40400000) begin errors++; $display("[TB] FAIL add_rsp_hold got %h expected 40400000", rsp_data); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL add_idle_busy got %b expected 0", busy); end
  endtask

  task automatic test_round_robin();
    logic [3:0]  exp_ready;
    logic [1:0]  exp_id;
    do_reset();
    for (int i = 0; i < N; i++) begin
      req_a[32*i +: 32] = 32'hA0000000 + 32'(i);
      req_b[32*i +: 32] = 32'h0;
      req_op[2*i +: 2]  = 2'd1;
    end
    for (int c = 0; c < 10; c++) begin
      if (c < 8) begin
        req_valid = 4'b1111;
        #1;
        exp_ready = 4'(1 << (c % 4));
        checks++; if (req_ready !== exp_ready) begin errors++; $display("[TB] FAIL rr_grant cycle %0d got %b expected %b", c, req_ready, exp_ready); end
      end else begin
        req_valid = '0;
      end
      step();
      if (c >= 2) begin
        exp_id = 2'((c - 2) % 4);
        checks++; if (rsp_valid !== 1'b1) begin errors++; $display("[TB] FAIL rr_rsp_valid cycle %0d got %b expected 1", c, rsp_valid); end
        checks++; if (rsp_id !== exp_id) begin errors++; $display("[TB] FAIL rr_rsp_id cycle %0d got %0d expected %0d", c, rsp_id, exp_id); end
        checks++; if (rsp_data !== (32'hA0000000 + 32'(exp_id))) begin errors++; $display("[TB] FAIL rr_rsp_data cycle %0d got %h expected %h", c, rsp_data, 32'hA0000000 + 32'(exp_id)); end
      end
    end
  endtask

  task automatic test_ops();
    logic [2:0]  exp_ctrl [0:2];
    logic [31:0] exp_data [0:2];
    exp_ctrl[0] = 3'b100; exp_ctrl[1] = 3'b010; exp_ctrl[2] = 3'b000;
    exp_data[0] = 32'h12345678; exp_data[1] = 32'h9ABCDEF0; exp_data[2] = 32'h00000000;
    do_reset();
    for (int c = 0; c < 5; c++) begin
      if (c < 3) begin
        req_valid         = 4'b0100;
        req_a[32*2 +: 32] = (c == 0) ? 32'h12345678 : 32'h55555555;
        req_b[32*2 +: 32] = (c == 1) ? 32'h9ABCDEF0 : 32'h66666666;
        req_op[2*2 +: 2]  = 2'(c + 1);
        #1;
        checks++; if (req_ready !== 4'b0100) begin errors++; $display("[TB] FAIL op_single_grant cycle %0d got %b expected 0100", c, req_ready); end
      end else begin
        req_valid = '0;
      end
      step();
      if (c < 3) begin
        checks++; if (add_ctrl !== exp_ctrl[c]) begin errors++; $display("[TB] FAIL op_ctrl cycle %0d got %b expected %b", c, add_ctrl, exp_ctrl[c]); end
      end
      if (c >= 2) begin
        checks++; if (rsp_valid !== 1'b1) begin errors++; $display("[TB] FAIL op_rsp_valid cycle %0d got %b expected 1", c, rsp_valid); end
        checks++; if (rsp_id !== 2'd2) begin errors++; $display("[TB] FAIL op_rsp_id cycle %0d got %0d expected 2", c, rsp_id); end
        checks++; if (rsp_data !== exp_data[c-2]) begin errors++; $display("[TB] FAIL op_rsp_data cycle %0d got %h expected %h", c, rsp_data, exp_data[c-2]); end
      end
    end
    checks++; if (add_ctrl !== 3'b000) begin errors++; $display("[TB] FAIL op_idle_ctrl got %b expected 000", add_ctrl); end
    checks++; if (add_a !== 32'h55555555) begin errors++; $display("[TB] FAIL op_hold_a got %h expected 55555555", add_a); end
  endtask

  task automatic test_pointer_wrap();
    do_reset();
    for (int i = 0; i < N; i++) req_op[2*i +: 2] = 2'd3;
    req_valid = 4'b0100;
    step();
    req_valid = 4'b0001;
    #1;
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("[TB] FAIL wrap_grant0 got %b expected 0001", req_ready); end
    step();
    req_valid = 4'b1010;
    #1;
    checks++; if (req_ready !== 4'b0010) begin errors++; $display("[TB] FAIL wrap_grant1 got %b expected 0010", req_ready); end
    step();
    req_valid = 4'b1000;
    #1;
    checks++; if (req_ready !== 4'b1000) begin errors++; $display("[TB] FAIL wrap_grant3 got %b expected 1000", req_ready); end
    step();
    req_valid = 4'b1111;
    #1;
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("[TB] FAIL wrap_after3 got %b expected 0001", req_ready); end
    req_valid = '0;
    step();
    step();
    step();
  endtask

  task automatic test_reset_midop();
    do_reset();
    for (int i = 0; i < N; i++) begin
      req_a[32*i +: 32] = 32'hC0DE0000 + 32'(i);
      req_op[2*i +: 2]  = 2'd1;
    end
    req_valid = 4'b0111;
    step();
    step();
    step();
    req_valid = '0;
    step();
    rst_n     = 1'b0;
    req_valid = 4'b1111;
    #1;
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("[TB] FAIL midrst_rsp_valid got %b expected 0", rsp_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL midrst_busy got %b expected 0", busy); end
    checks++; if (add_ctrl !== 3'b000) begin errors++; $display("[TB] FAIL midrst_ctrl got %b expected 000", add_ctrl); end
    checks++; if (add_a !== 32'd0) begin errors++; $display("[TB] FAIL midrst_add_a got %h expected 0", add_a); end
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("[TB] FAIL midrst_ready got %b expected 0000", req_ready); end
    step();
    step();
    rst_n     = 1'b1;
    req_valid = '0;
    for (int c = 0; c < 4; c++) begin
      step();
      checks++; if (rsp_valid !== 1'b0) begin errors++; $display("[TB] FAIL postrst_rsp cycle %0d got %b expected 0", c, rsp_valid); end
      checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL postrst_busy cycle %0d got %b expected 0", c, busy); end
    end
    req_valid = 4'b1111;
    #1;
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("[TB] FAIL postrst_ptr got %b expected 0001", req_ready); end
    req_valid = '0;
    step();
  endtask

`ifdef ARB_STATS_EN
  task automatic test_stats();
    do_reset();
    stats_clr = 1'b0;
    req_valid = 4'b0001;
    for (int c = 0; c < 5; c++) step();
    req_valid = 4'b1000;
    for (int c = 0; c < 2; c++) step();
    req_valid = '0;
    checks++; if (grant_cnt !== {16'd2, 16'd0, 16'd0, 16'd5}) begin errors++; $display("[TB] FAIL stats_count got %h expected 0002000000000005", grant_cnt); end
    req_valid = 4'b0001;
    stats_clr = 1'b1;
    step();
    stats_clr = 1'b0;
    req_valid = '0;
    checks++; if (grant_cnt !== 64'd0) begin errors++; $display("[TB] FAIL stats_clear got %h expected 0", grant_cnt); end
  endtask
`endif

  initial begin
    rst_n     = 1'b0;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    req_op    = '0;
`ifdef ARB_STATS_EN
    stats_clr = 1'b0;
`endif
    test_reset();
    test_single_add();
    test_round_robin();
    test_ops();
    test_pointer_wrap();
    test_reset_midop();
`ifdef ARB_STATS_EN
    test_stats();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
